// File: rtl/pc_sequencer.sv
// Control-flow sequencer driving the program counter's control inputs from a
// decoded instruction stream; resolves jumps, branches and call/return.
module pc_sequencer #(
    parameter int STACK_DEPTH = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         InstrValid,
    input  logic [2:0]                   Opcode,
    input  logic [ADDR_W-1:0]            Target,
    input  logic signed [8:0]            BranchOffset,
    input  logic                         ZeroFlag,
    input  logic [ADDR_W-1:0]            PcValue,
    input  logic                         Resume,
    output logic                         PcReset,
    output logic [ADDR_W-1:0]            PcLoadValue,
    output logic                         PcLoadEnable,
    output logic signed [8:0]            PcOffset,
    output logic                         PcOffsetEnable,
    output logic                         Halted,
    output logic                         Fault,
    output logic [$clog2(STACK_DEPTH):0] StackLevel
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BRZ  = 3'd2;
    localparam logic [2:0] OP_BRNZ = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        HALTED,
        FAULT
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [LVL_W-1:0]  sp;
    logic [PTR_W-1:0]  push_idx;
    logic [PTR_W-1:0]  top_idx;
    logic              stack_full;
    logic              stack_empty;
    logic              push;
    logic              pop;
    logic              hold;

    assign stack_full  = (sp == LVL_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign push_idx    = PTR_W'(sp);
    assign top_idx     = PTR_W'(sp - LVL_W'(1));

    // NOTE: every output and flag gets a default before the case so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next     = state;
        PcReset        = 1'b0;
        PcLoadValue    = '0;
        PcLoadEnable   = 1'b0;
        PcOffset       = '0;
        PcOffsetEnable = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        hold           = 1'b0;

        unique case (state)
            INIT: begin
                PcReset    = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (!InstrValid) begin
                    hold = 1'b1;
                end else begin
                    case (Opcode)
                        OP_JMP: begin
                            PcLoadEnable = 1'b1;
                            PcLoadValue  = Target;
                        end
                        OP_BRZ, OP_BRNZ: begin
                            if (ZeroFlag == (Opcode == OP_BRZ)) begin
                                PcOffsetEnable = 1'b1;
                                PcOffset       = BranchOffset;
                            end
                        end
                        OP_CALL: begin
                            if (!stack_full) begin
                                push         = 1'b1;
                                PcLoadEnable = 1'b1;
                                PcLoadValue  = Target;
                            end else begin
                                hold       = 1'b1;
                                state_next = FAULT;
                            end
                        end
                        OP_RET: begin
                            if (!stack_empty) begin
                                pop          = 1'b1;
                                PcLoadEnable = 1'b1;
                                PcLoadValue  = stack_mem[top_idx];
                            end else begin
                                hold       = 1'b1;
                                state_next = FAULT;
                            end
                        end
                        OP_HALT: begin
                            hold       = 1'b1;
                            state_next = HALTED;
                        end
                        default: ;  // NOP and reserved let the PC self-increment
                    endcase
                end
            end
            HALTED: begin
                hold = 1'b1;
                if (Resume) state_next = RUN;
            end
            FAULT: begin
                hold = 1'b1;
            end
        endcase

        // A hold is a zero-offset step, which suppresses the PC's increment.
        if (hold) PcOffsetEnable = 1'b1;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= INIT;
            sp    <= '0;
        end else begin
            state <= state_next;
            if (push)     sp <= sp + LVL_W'(1);
            else if (pop) sp <= sp - LVL_W'(1);
        end
    end

    // NOTE: the return-address storage has no reset; entries above the stack
    // pointer are never read, so clearing them would buy nothing.
    always_ff @(posedge Clock) begin
        if (push) stack_mem[push_idx] <= PcValue + ADDR_W'(1);
    end

    assign Halted     = (state == HALTED);
    assign Fault      = (state == FAULT);
    assign StackLevel = sp;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a PC register closes the loop, and a
// queue-based reference model is compared against every output each cycle.
module tb_pc_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 16;

    localparam int M_INIT   = 0;
    localparam int M_RUN    = 1;
    localparam int M_HALTED = 2;
    localparam int M_FAULT  = 3;

    logic                 Clock = 1'b0;
    logic                 Reset = 1'b1;
    logic                 InstrValid = 1'b0;
    logic [2:0]           Opcode = '0;
    logic [AW-1:0]        Target = '0;
    logic signed [8:0]    BranchOffset = '0;
    logic                 ZeroFlag = 1'b0;
    logic [AW-1:0]        PcValue;
    logic                 Resume = 1'b0;
    logic                 PcReset;
    logic [AW-1:0]        PcLoadValue;
    logic                 PcLoadEnable;
    logic signed [8:0]    PcOffset;
    logic                 PcOffsetEnable;
    logic                 Halted;
    logic                 Fault;
    logic [3:0]           StackLevel;

    int n_checks = 0;
    int n_err    = 0;

    pc_sequencer #(.STACK_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .InstrValid     (InstrValid),
        .Opcode         (Opcode),
        .Target         (Target),
        .BranchOffset   (BranchOffset),
        .ZeroFlag       (ZeroFlag),
        .PcValue        (PcValue),
        .Resume         (Resume),
        .PcReset        (PcReset),
        .PcLoadValue    (PcLoadValue),
        .PcLoadEnable   (PcLoadEnable),
        .PcOffset       (PcOffset),
        .PcOffsetEnable (PcOffsetEnable),
        .Halted         (Halted),
        .Fault          (Fault),
        .StackLevel     (StackLevel)
    );

    always #5 Clock = ~Clock;

    // Program counter the sequencer controls.
    logic [AW-1:0] pc = '0;
    assign PcValue = pc;
    always @(posedge Clock) begin
        if (PcReset)             pc <= '0;
        else if (PcLoadEnable)   pc <= PcLoadValue;
        else if (PcOffsetEnable) pc <= pc + {{(AW-9){PcOffset[8]}}, PcOffset};
        else                     pc <= pc + 16'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode plus a queue of return addresses.
    int            m_mode = M_INIT;
    logic [AW-1:0] ret_q[$];
    int            pend_mode = M_INIT;
    int            pend_op = 0;
    logic [AW-1:0] pend_val = '0;

    always @(negedge Clock) begin
        logic e_rst, e_le, e_oe, hold;
        logic [AW-1:0] e_lv;
        logic [8:0] e_off;
        int nmode, nop;
        logic [AW-1:0] nval;
        e_rst = 0; e_le = 0; e_oe = 0; hold = 0; e_lv = '0; e_off = '0;
        nmode = m_mode; nop = 0; nval = '0;
        case (m_mode)
            M_INIT: begin e_rst = 1; nmode = M_RUN; end
            M_RUN: begin
                if (!InstrValid) hold = 1;
                else case (Opcode)
                    3'd1: begin e_le = 1; e_lv = Target; end
                    3'd2: if (ZeroFlag)  begin e_oe = 1; e_off = BranchOffset; end
                    3'd3: if (!ZeroFlag) begin e_oe = 1; e_off = BranchOffset; end
                    3'd4: if (ret_q.size() < DEPTH) begin
                              nop = 1; nval = PcValue + 16'd1; e_le = 1; e_lv = Target;
                          end else begin hold = 1; nmode = M_FAULT; end
                    3'd5: if (ret_q.size() > 0) begin
                              nop = 2; e_le = 1; e_lv = ret_q[$];
                          end else begin hold = 1; nmode = M_FAULT; end
                    3'd6: begin hold = 1; nmode = M_HALTED; end
                    default: ;
                endcase
            end
            M_HALTED: begin hold = 1; if (Resume) nmode = M_RUN; end
            default: hold = 1;
        endcase
        if (hold) e_oe = 1;
        check("outputs",
              {PcReset, PcLoadEnable, PcLoadValue, PcOffsetEnable, PcOffset, Halted, Fault, StackLevel},
              {e_rst, e_le, e_lv, e_oe, e_off, (m_mode == M_HALTED), (m_mode == M_FAULT),
               4'(ret_q.size())});
        pend_mode = nmode;
        pend_op   = nop;
        pend_val  = nval;
    end

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_mode <= M_INIT;
            ret_q.delete();
        end else begin
            m_mode <= pend_mode;
            if (pend_op == 1)      ret_q.push_back(pend_val);
            else if (pend_op == 2) void'(ret_q.pop_back());
        end
    end

    task automatic step(input logic v, input logic [2:0] op, input logic [AW-1:0] tgt,
                        input logic signed [8:0] off, input logic zf, input logic res);
        InstrValid = v; Opcode = op; Target = tgt; BranchOffset = off;
        ZeroFlag = zf; Resume = res;
        @(posedge Clock); #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; InstrValid = 1'b0; Resume = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b0;
        step(0, 0, 0, 0, 0, 0);
    endtask

    logic [AW-1:0] ra [DEPTH];
    logic [AW-1:0] saved;

    initial begin
        @(posedge Clock); @(posedge Clock); #1;
        check("reset_outputs",
              {PcReset, PcLoadEnable, PcLoadValue, PcOffsetEnable, PcOffset, Halted, Fault, StackLevel},
              {1'b1, 33'd0});
        Reset = 1'b0;
        check("init_pcreset", PcReset, 1'b1);
        step(0, 0, 0, 0, 0, 0);
        check("run_pcreset", PcReset, 1'b0);
        check("pc_after_init", pc, 16'h0000);
        for (int i = 0; i < 8; i++) step(1, 3'd0, 0, 0, 0, 0);
        check("pc_after_nops", pc, 16'h0008);
        check("level_after_nops", StackLevel, 4'd0);

        step(1, 3'd1, 16'h0100, 0, 0, 0);
        check("jmp", pc, 16'h0100);
        step(1, 3'd2, 0, -9'sd4, 1, 0);
        check("brz_taken", pc, 16'h00FC);
        step(1, 3'd3, 0, 9'sd5, 1, 0);
        check("brnz_not_taken", pc, 16'h00FD);
        step(1, 3'd2, 0, 9'sd0, 1, 0);
        check("brz_zero_offset", pc, 16'h00FD);

        step(1, 3'd1, 16'h0010, 0, 0, 0);
        step(1, 3'd4, 16'h0200, 0, 0, 0);
        check("call_pc", pc, 16'h0200);
        check("call_level", StackLevel, 4'd1);
        step(1, 3'd5, 0, 0, 0, 0);
        check("ret_pc", pc, 16'h0011);
        check("ret_level", StackLevel, 4'd0);

        for (int i = 0; i < DEPTH; i++) begin
            ra[i] = (i == 0) ? 16'h0012 : 16'h1000 + 16'(i - 1) * 16'h0100 + 16'h0001;
            step(1, 3'd4, 16'h1000 + 16'(i) * 16'h0100, 0, 0, 0);
        end
        check("nested_level", StackLevel, 4'd8);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            step(1, 3'd5, 0, 0, 0, 0);
            check("lifo_ret", pc, ra[i]);
        end

        for (int i = 0; i < DEPTH; i++) step(1, 3'd4, 16'h1000 + 16'(i) * 16'h0100, 0, 0, 0);
        saved = pc;
        step(1, 3'd4, 16'h2000, 0, 0, 0);
        check("overflow_fault", Fault, 1'b1);
        check("overflow_pc", pc, saved);
        check("overflow_level", StackLevel, 4'd8);
        step(1, 3'd1, 16'h0ABC, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("fault_sticky", Fault, 1'b1);
        check("fault_pc", pc, saved);

        Reset = 1'b1; #1;
        check("reset_clears_fault", Fault, 1'b0);
        check("reset_clears_level", StackLevel, 4'd0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        step(1, 3'd5, 0, 0, 0, 0);
        check("underflow_fault", Fault, 1'b1);
        check("underflow_pc", pc, 16'h0000);

        do_reset();
        step(1, 3'd1, 16'h0030, 0, 0, 0);
        step(1, 3'd6, 0, 0, 0, 0);
        check("halted", Halted, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1, 3'd1, 16'h0777, 0, 0, 0);
            check("halt_pc", pc, 16'h0030);
        end
        step(1, 3'd1, 16'h0999, 0, 0, 1);
        check("resume_pc", pc, 16'h0030);
        check("resume_run", Halted, 1'b0);
        step(1, 3'd0, 0, 0, 0, 0);
        check("after_resume_pc", pc, 16'h0031);

        step(1, 3'd1, 16'h0040, 0, 0, 0);
        InstrValid = 1; Opcode = 3'd4; Target = 16'h0300;
        #2; Reset = 1'b1; #1;
        check("midcall_pcreset", PcReset, 1'b1);
        check("midcall_level", StackLevel, 4'd0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        step(1, 3'd5, 0, 0, 0, 0);
        check("midcall_no_push", Fault, 1'b1);

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int r, k;
            r = $urandom_range(0, 99);
            if (r == 0 || (m_mode == M_FAULT && r < 20)) begin
                do_reset();
            end else begin
                k = $urandom_range(0, 11);
                step($urandom_range(0, 9) != 0,
                     (k < 8) ? 3'(k) : ((k < 10) ? 3'd4 : 3'd5),
                     16'($urandom), 9'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Control-flow sequencer that drives the program counter's control inputs (sync reset, LoadValue/LoadEnable, Offset/OffsetEnable) from a decoded instruction stream. It resolves jumps, conditional relative branches, and call/return through an internal return-address stack. It also handles halt/resume and stack faults. It sits between the instruction decode stage and the program counter and is the only block that drives the PC's control inputs.

Parameters:
STACK_DEPTH, 8, number of return-address entries (power of two, 2..16)
ADDR_W, 16, PC/address width; must match the program counter width

Ports:
Clock  in  1  system clock, all state updates on posedge
Reset  in  1  asynchronous, active-high reset
InstrValid  in  1  Opcode/Target/BranchOffset valid this cycle
Opcode  in  3  0 NOP, 1 JMP, 2 BRZ, 3 BRNZ, 4 CALL, 5 RET, 6 HALT, 7 reserved (treated as NOP)
Target  in  ADDR_W  absolute target for JMP/CALL
BranchOffset  in  9  signed relative offset for BRZ/BRNZ
ZeroFlag  in  1  ALU zero flag, sampled for BRZ/BRNZ
PcValue  in  ADDR_W  current PC CounterValue
Resume  in  1  leave HALTED (level, sampled on posedge)
PcReset  out  1  to PC synchronous Reset
PcLoadValue  out  ADDR_W  to PC LoadValue
PcLoadEnable  out  1  to PC LoadEnable
PcOffset  out  9  signed, to PC Offset
PcOffsetEnable  out  1  to PC OffsetEnable
Halted  out  1  state == HALTED
Fault  out  1  state == FAULT
StackLevel  out  $clog2(STACK_DEPTH)+1  occupied stack entries

Behaviour:
- Reset asserted (async): state=INIT, stack pointer=0, stack contents don't-care. PcReset=1; all other outputs 0; StackLevel=0.
- States: INIT, RUN, HALTED, FAULT.
- INIT: PcReset=1 for exactly one cycle after Reset deasserts, so the PC's synchronous reset is sampled. Next state RUN.
- All PC control outputs are combinational from state plus current inputs. The PC acts on them at the same posedge, so control-flow latency is 0 cycles: the new PC is visible the cycle after the instruction.
- Hold is encoded as PcOffsetEnable=1 with PcOffset=0. The PC otherwise self-increments by 1.
- RUN with InstrValid=0: hold.
- RUN with InstrValid=1, by Opcode:
  - NOP/reserved: all enables 0 (PC+1).
  - JMP: PcLoadEnable=1, PcLoadValue=Target.
  - BRZ: if ZeroFlag=1, PcOffsetEnable=1 and PcOffset=BranchOffset; else PC+1.
  - BRNZ: same as BRZ with the condition inverted.
  - CALL: if StackLevel<STACK_DEPTH, push PcValue+1 (wraps modulo 2^ADDR_W), then load Target. If the stack is full: no push, hold, next state FAULT.
  - RET: if StackLevel>0, pop; PcLoadValue=top entry, PcLoadEnable=1. If the stack is empty: hold, next state FAULT.
  - HALT: hold; next state HALTED.
- HALTED: hold every cycle and ignore InstrValid. Resume=1 moves to RUN at the next posedge; the instruction presented in that same cycle is ignored.
- FAULT: hold every cycle and ignore all inputs. Only Reset exits FAULT.
- PcLoadEnable and PcOffsetEnable are never both 1. PcLoadValue and PcOffset are 0 whenever their enable is 0.
- A BranchOffset of 0 on a taken branch is legal and equals a hold.
- Reset mid-operation (any state, any cycle) clears the stack and forces INIT asynchronously. Outputs update immediately.
- StackLevel changes on the posedge following a successful CALL (+1) or RET (-1).

Test Plan:
- Reset released → PcReset=1 for 1 cycle, then RUN. Eight NOPs take PC 0→8. StackLevel=0.
- JMP Target=0x0100, then BRZ offset=-4 with ZeroFlag=1 → PC 0x0100, then 0x00FC. BRNZ offset=+5 with ZeroFlag=1 → PC 0x00FD (not taken).
- At PC=0x0010, CALL Target=0x0200 → PC=0x0200, StackLevel=1. RET → PC=0x0011, StackLevel=0. Nested CALLs to depth 8 return in LIFO order.
- Ninth CALL with a full stack → Fault=1, PC frozen, StackLevel stays 8. Later JMP/Resume are ignored. Reset clears Fault and StackLevel.
- RET with an empty stack → Fault=1, PC unchanged. HALT at PC=0x0030 → Halted=1, PC stays 0x0030 for 5 cycles. Resume=1 → RUN, PC 0x0031 the following cycle.
- Reset asserted mid-CALL cycle, asynchronously between edges → PcReset=1 immediately, StackLevel=0, no push recorded.
